// File: rtl/tuner_window_ctrl.sv
// Window sequencer for the tuner correlator bank.
// Frames accepted audio samples into 2**window_log2_p windows, clears the MACs
// at each window start, then stalls the stream while it walks the magnitude mux
// over every note channel and reports the index of the strongest one.
module tuner_window_ctrl #(
    parameter int num_notes_p   = 7,
    parameter int window_log2_p = 16,
    parameter int mag_width_p   = 32,
    parameter int idx_width_p   = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          mac_clear_o,
    output logic                          mac_en_o,
    output logic [idx_width_p-1:0]        mag_sel_o,
    input  logic signed [mag_width_p-1:0] mag_i,
    output logic [idx_width_p-1:0]        note_o,
    output logic                          note_valid_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACCUM  = 2'd1,
        SCAN   = 2'd2,
        REPORT = 2'd3
    } state_e;

    localparam logic [idx_width_p-1:0]        LAST_SEL = idx_width_p'(num_notes_p - 1);
    localparam logic signed [mag_width_p-1:0] MOST_NEG = {1'b1, {(mag_width_p-1){1'b0}}};

    state_e                   state_q, state_d;
    logic [window_log2_p-1:0] count_q, count_d;
    logic [idx_width_p-1:0]   mag_sel_q, mag_sel_d;
    logic [mag_width_p-2:0]   best_mag_q, best_mag_d;
    logic [idx_width_p-1:0]   best_idx_q, best_idx_d;
    logic [idx_width_p-1:0]   note_q, note_d;
    logic                     note_valid_q, note_valid_d;
    logic [mag_width_p-2:0]   abs_mag;

    // Magnitude of a signed accumulator; the most-negative value has no positive
    // twin in mag_width_p-1 bits, so it saturates to all-ones instead of wrapping.
    function automatic logic [mag_width_p-2:0] sat_abs(input logic signed [mag_width_p-1:0] v);
        logic signed [mag_width_p-1:0] neg;
        neg = -v;
        if (!v[mag_width_p-1]) begin
            return v[mag_width_p-2:0];
        end
        if (v == MOST_NEG) begin
            return '1;
        end
        return neg[mag_width_p-2:0];
    endfunction

    // Magnitude of the channel currently selected on the external mux.
    always_comb begin
        abs_mag = sat_abs(mag_i);
    end

    // Next-state logic: window counting, serial max search, report handoff.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        mag_sel_d    = mag_sel_q;
        best_mag_d   = best_mag_q;
        best_idx_d   = best_idx_q;
        note_d       = note_q;
        note_valid_d = note_valid_q;

        case (state_q)
            CLEAR: begin
                count_d = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                if (valid_i) begin
                    count_d = count_q + 1'b1;
                    if (count_q == '1) begin
                        // Start a fresh search; best_idx is cleared too so an
                        // all-zero window reports channel 0, not a stale winner.
                        mag_sel_d  = '0;
                        best_mag_d = '0;
                        best_idx_d = '0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                // Strict compare: on a tie the earlier (lower) index is kept.
                if (abs_mag > best_mag_q) begin
                    best_mag_d = abs_mag;
                    best_idx_d = mag_sel_q;
                end
                if (mag_sel_q == LAST_SEL) begin
                    note_d       = best_idx_d;
                    note_valid_d = 1'b1;
                    mag_sel_d    = '0;
                    state_d      = REPORT;
                end else begin
                    mag_sel_d = mag_sel_q + 1'b1;
                end
            end
            REPORT: begin
                note_valid_d = 1'b0;
                state_d      = CLEAR;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State register with asynchronous return to the window-start condition.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= CLEAR;
            count_q      <= '0;
            mag_sel_q    <= '0;
            best_mag_q   <= '0;
            best_idx_q   <= '0;
            note_q       <= '0;
            note_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            mag_sel_q    <= mag_sel_d;
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
        end
    end

    // Outputs decoded from registered state; only mac_en_o sees valid_i directly.
    always_comb begin
        ready_o      = (state_q == ACCUM);
        mac_clear_o  = (state_q == CLEAR);
        mac_en_o     = valid_i & ready_o;
        busy_o       = (state_q != ACCUM);
        mag_sel_o    = mag_sel_q;
        note_o       = note_q;
        note_valid_o = note_valid_q;
    end

endmodule

// File: tb/tb_tuner_window_ctrl.sv
// Bench for tuner_window_ctrl with 8-sample windows and 7 note channels.
module tb_tuner_window_ctrl;

    localparam int NN  = 7;
    localparam int WL  = 3;
    localparam int MW  = 32;
    localparam int IW  = 3;
    localparam int WIN = 1 << WL;

    logic                 clk;
    logic                 reset_ni;
    logic                 valid_i;
    logic                 ready_o;
    logic                 mac_clear_o;
    logic                 mac_en_o;
    logic [IW-1:0]        mag_sel_o;
    logic signed [MW-1:0] mag_i;
    logic [IW-1:0]        note_o;
    logic                 note_valid_o;
    logic                 busy_o;

    tuner_window_ctrl #(
        .num_notes_p  (NN),
        .window_log2_p(WL),
        .mag_width_p  (MW),
        .idx_width_p  (IW)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mac_clear_o (mac_clear_o),
        .mac_en_o    (mac_en_o),
        .mag_sel_o   (mag_sel_o),
        .mag_i       (mag_i),
        .note_o      (note_o),
        .note_valid_o(note_valid_o),
        .busy_o      (busy_o)
    );

    typedef struct packed {
        logic [NN-1:0][MW-1:0] mags;
        logic [7:0]            gap;
        logic [IW-1:0]         exp_note;
    } vec_t;

    typedef struct {
        int note;
        int cyc;
    } sb_t;

    vec_t                  vecs[$];
    sb_t                   sb[$];
    int                    pulse_cyc[$];
    logic [NN-1:0][MW-1:0] cur_mags;
    int                    cur_exp;
    int                    total;
    int                    bad;
    int                    cyc;
    int                    hs_cnt;
    int                    mac_en_total;
    int                    last_note;

    // External magnitude mux model.
    assign mag_i = (mag_sel_o < IW'(NN)) ? cur_mags[mag_sel_o] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_vec(input int m0, input int m1, input int m2, input int m3,
                           input int m4, input int m5, input int m6,
                           input int gap, input int e);
        vec_t v;
        v.mags     = {m6, m5, m4, m3, m2, m1, m0};
        v.gap      = 8'(gap);
        v.exp_note = IW'(e);
        vecs.push_back(v);
    endtask

    // Scoreboard monitor: counts handshakes, queues the expected report when a
    // window completes, and matches it against the note_valid_o pulse.
    initial begin
        sb_t e;
        hs_cnt       = 0;
        mac_en_total = 0;
        last_note    = 0;
        forever begin
            @(negedge clk);
            if (!reset_ni) begin
                hs_cnt    = 0;
                last_note = 0;
                sb.delete();
            end else begin
                if (mac_en_o) begin
                    mac_en_total = mac_en_total + 1;
                    check("hs_while_busy", busy_o, 0);
                    hs_cnt = hs_cnt + 1;
                    if (hs_cnt == WIN) begin
                        hs_cnt = 0;
                        sb.push_back('{cur_exp, cyc + NN + 1});
                    end
                end
                if (note_valid_o) begin
                    pulse_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("note", note_o, e.note);
                        check("report_cycle", cyc, e.cyc);
                        last_note = e.note;
                    end
                end else begin
                    check("note_hold", note_o, last_note);
                end
            end
        end
    end

    task automatic send_sample();
        int n;
        n = 0;
        valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            n = n + 1;
            if (n > 200) begin
                check("ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_window(input int gap);
        for (int i = 0; i < WIN; i++) begin
            send_sample();
            if (gap > 0) begin
                valid_i = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_report();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n = n + 1;
        end
        check("report_seen", sb.size(), 0);
        sb.delete();
        #1;
    endtask

    initial begin
        int en0;
        int n;
        total    = 0;
        bad      = 0;
        cur_mags = '0;
        cur_exp  = 0;
        valid_i  = 1'b1;
        reset_ni = 1'b0;

        add_vec(100, -300, 50, 299, 0, 7, -1, 0, 1);
        add_vec(5, -5, 5, 0, 0, 0, 0, 1, 0);
        add_vec(0, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 6);
        add_vec(0, 0, 0, 0, 0, 0, 0, 2, 0);
        add_vec(-2147483647, 0, 0, 0, 0, 0, 32'h8000_0000, 0, 0);
        add_vec(1, 2, 3, 4, 5, 6, 7, 0, 6);
        add_vec(0, 0, 0, -40, 39, 40, 0, 1, 3);

        // Reset held: CLEAR outputs, no handshake even with valid_i high.
        repeat (2) begin
            @(negedge clk);
            check("rst_mac_clear", mac_clear_o, 1);
            check("rst_ready", ready_o, 0);
            check("rst_mac_en", mac_en_o, 0);
            check("rst_note", note_o, 0);
            check("rst_note_valid", note_valid_o, 0);
            check("rst_mag_sel", mag_sel_o, 0);
            check("rst_busy", busy_o, 1);
        end
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        reset_ni = 1'b1;
        @(negedge clk);
        check("post_rst_clear", mac_clear_o, 1);
        check("post_rst_ready", ready_o, 0);
        @(negedge clk);
        check("idle_ready", ready_o, 1);
        check("idle_clear", mac_clear_o, 0);
        check("idle_busy", busy_o, 0);
        repeat (5) @(negedge clk);
        check("idle_ready_hold", ready_o, 1);
        check("idle_note_valid", note_valid_o, 0);
        @(posedge clk);
        #1;

        // Table-driven windows.
        for (int v = 0; v < vecs.size(); v++) begin
            cur_mags = vecs[v].mags;
            cur_exp  = int'(vecs[v].exp_note);
            en0      = mac_en_total;
            send_window(int'(vecs[v].gap));
            valid_i = 1'b0;
            if (v == 0) begin
                for (int s = 0; s < NN; s++) begin
                    @(negedge clk);
                    check("scan_sel", mag_sel_o, s);
                    check("scan_ready", ready_o, 0);
                    check("scan_busy", busy_o, 1);
                end
            end
            wait_report();
            check("win_mac_en", mac_en_total - en0, WIN);
            if (v == 0) begin
                @(negedge clk);
                check("clear_after_report", mac_clear_o, 1);
                check("clear_sel", mag_sel_o, 0);
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a scan: the pending report is dropped.
        cur_exp = 3;
        send_window(0);
        valid_i = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (busy_o && mag_sel_o == 3'd3) break;
            n = n + 1;
            if (n > 20) begin
                check("scan_sel3_timeout", 0, 1);
                break;
            end
        end
        #1;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_note", note_o, 0);
        check("mid_rst_note_valid", note_valid_o, 0);
        check("mid_rst_clear", mac_clear_o, 1);
        check("mid_rst_sel", mag_sel_o, 0);
        check("mid_rst_ready", ready_o, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_note_valid", note_valid_o, 0);
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        cur_mags = {32'd0, 32'd0, 32'd0, 32'd0, -32'sd8, 32'd0, 32'd0};
        cur_exp  = 2;
        send_window(0);
        valid_i = 1'b0;
        wait_report();

        // valid_i held high across three back-to-back windows.
        cur_mags = {32'd0, 32'd0, 32'd39, -32'sd40, 32'd0, 32'd0, 32'd0};
        cur_exp  = 3;
        pulse_cyc.delete();
        en0 = mac_en_total;
        repeat (3) send_window(0);
        valid_i = 1'b0;
        wait_report();
        check("bb_mac_en", mac_en_total - en0, 3 * WIN);
        check("bb_pulses", pulse_cyc.size(), 3);
        if (pulse_cyc.size() == 3) begin
            check("bb_space0", pulse_cyc[1] - pulse_cyc[0], WIN + NN + 2);
            check("bb_space1", pulse_cyc[2] - pulse_cyc[1], WIN + NN + 2);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
